imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pkg.sv | 14 +
 rtl/imm_decode.sv | 46 ++++
 rtl/imm_gen_pipe.sv | 88 ++++++++
 tb/tb_imm_gen_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared immediate-format encoding and input width for the immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100
  } imm_fmt_t;

  localparam int IMM_IN_W = 25;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate format mux with sign extension to XLEN.
// Optional o_err port exists only when IMM_GEN_ERR_EN is defined.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [IMM_IN_W-1:0] i_imm,
  input  logic [2:0]          i_imm_src,
  output logic [XLEN-1:0]     o_value
`ifdef IMM_GEN_ERR_EN
  ,
  output logic                o_err
`endif
);

  logic signed [31:0] w_raw;
  logic               w_err;

  // Every format is built as a 32-bit signed value, then widened by a signed cast.
  always_comb begin
    w_raw = '0;
    w_err = 1'b0;
    case (imm_fmt_t'(i_imm_src))
      FMT_I: w_raw = {{20{i_imm[24]}}, i_imm[24:13]};
      FMT_S: w_raw = {{20{i_imm[24]}}, i_imm[24:18], i_imm[4:0]};
      FMT_B: w_raw = {{19{i_imm[24]}}, i_imm[24], i_imm[0], i_imm[23:18], i_imm[4:1], 1'b0};
      FMT_U: w_raw = {i_imm[24:5], 12'b0};
      FMT_J: w_raw = {{11{i_imm[24]}}, i_imm[24], i_imm[12:5], i_imm[13], i_imm[23:14], 1'b0};
      default: begin
        w_raw = '0;
        w_err = 1'b1;
      end
    endcase
  end

  assign o_value = XLEN'(w_raw);

`ifdef IMM_GEN_ERR_EN
  assign o_err = w_err;
`else
  logic w_err_unused;
  assign w_err_unused = w_err;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with valid/ready handshake: output register plus one-entry skid.
// Error flag storage is present only when IMM_GEN_ERR_EN is defined.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMM_IN_W-1:0] imm,
  input  logic [2:0]          imm_src,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     imm_ext,
  output logic                out_err
);

`ifdef IMM_GEN_ERR_EN
  localparam int DW = XLEN + 1;
`else
  localparam int DW = XLEN;
`endif

  logic [XLEN-1:0] w_val;
  logic [DW-1:0]   w_din;
  logic            w_acc;

  logic            r_o_vld;
  logic [DW-1:0]   r_o_dat;
  logic            r_s_vld;
  logic [DW-1:0]   r_s_dat;
  logic            r_in_rdy;

`ifdef IMM_GEN_ERR_EN
  logic w_err;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_imm     (imm),
    .i_imm_src (imm_src),
    .o_value   (w_val),
    .o_err     (w_err)
  );
  assign w_din = {w_err, w_val};
  assign {out_err, imm_ext} = r_o_dat;
`else
  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_imm     (imm),
    .i_imm_src (imm_src),
    .o_value   (w_val)
  );
  assign w_din   = w_val;
  assign imm_ext = r_o_dat;
  assign out_err = 1'b0;
`endif

  assign w_acc     = in_valid && r_in_rdy;
  assign in_ready  = r_in_rdy;
  assign out_valid = r_o_vld;

  // S can only be valid while O is valid, so an empty O implies an empty S.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_vld  <= 1'b0;
      r_o_dat  <= '0;
      r_s_vld  <= 1'b0;
      r_s_dat  <= '0;
      r_in_rdy <= 1'b0;
    end else if (!r_o_vld || out_ready) begin
      r_in_rdy <= 1'b1;
      if (r_s_vld) begin
        r_o_vld <= 1'b1;
        r_o_dat <= r_s_dat;
        r_s_vld <= 1'b0;
      end else begin
        r_o_vld <= w_acc;
        if (w_acc) r_o_dat <= w_din;
      end
    end else if (w_acc) begin
      r_s_vld  <= 1'b1;
      r_s_dat  <= w_din;
      r_in_rdy <= 1'b0;
    end else begin
      r_in_rdy <= !r_s_vld;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe against an arithmetic reference model.
module tb_imm_gen_pipe;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [24:0]     imm;
  logic [2:0]      imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_ext;
  logic            out_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [XLEN:0] exp_q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .imm_src   (imm_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_ext   (imm_ext),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Immediate as an integer offset: gather the field value, then subtract 2^width if negative.
  function automatic logic [XLEN:0] ref_model(input logic [24:0] im, input logic [2:0] src);
    longint f;
    int     w;
    bit     e;
    logic [63:0] v;
    e = 0;
    w = 1;
    f = 0;
    case (src)
      3'd0: begin f = longint'(im[24:13]); w = 12; end
      3'd1: begin f = longint'(im[24:18]) * 32 + longint'(im[4:0]); w = 12; end
      3'd2: begin
        f = longint'(im[24]) * 4096 + longint'(im[0]) * 2048
          + longint'(im[23:18]) * 32 + longint'(im[4:1]) * 2;
        w = 13;
      end
      3'd3: begin f = longint'(im[24:5]) * 4096; w = 32; end
      3'd4: begin
        f = longint'(im[24]) * 1048576 + longint'(im[12:5]) * 4096
          + longint'(im[13]) * 2048 + longint'(im[23:14]) * 2;
        w = 21;
      end
      default: e = 1;
    endcase
    if (!e && im[24]) f = f - (longint'(1) << w);
    v = f;
`ifdef IMM_GEN_ERR_EN
    return {e, v[XLEN-1:0]};
`else
    return {1'b0, v[XLEN-1:0]};
`endif
  endfunction

  // Drive one cycle from just after a falling edge; check outputs against model occupancy.
  task automatic cycle(input logic iv, input logic [24:0] im, input logic [2:0] src,
                       input logic ordy);
    in_valid  = iv;
    imm       = im;
    imm_src   = src;
    out_ready = ordy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    if (out_valid && exp_q.size() != 0) begin
      chk("imm_ext", 64'(imm_ext), 64'(exp_q[0][XLEN-1:0]));
      chk("out_err", {63'd0, out_err}, {63'd0, exp_q[0][XLEN]});
      if (ordy) void'(exp_q.pop_front());
    end
    if (iv && in_ready) exp_q.push_back(ref_model(im, src));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_imm_ext", 64'(imm_ext), 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic directed(input string tag, input logic [24:0] im, input logic [2:0] src,
                          input logic [XLEN-1:0] exp);
    cycle(1'b1, im, src, 1'b1);
    chk(tag, 64'(imm_ext), 64'(exp));
    cycle(1'b0, '0, 3'd0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    imm       = '0;
    imm_src   = '0;
    do_reset();

    directed("dir_I", 25'h1FFE000, 3'd0, 32'hFFFF_FFFF);
    directed("dir_S", 25'h1000000, 3'd1, 32'hFFFF_F800);
    directed("dir_U", 25'h02468A0, 3'd3, 32'h1234_5000);
    directed("dir_B", 25'h1FFFFFF, 3'd2, 32'hFFFF_FFFE);
    directed("dir_J", 25'h0004000, 3'd4, 32'h0000_0002);

    cycle(1'b1, 25'h1ABCDEF, 3'd7, 1'b1);
    chk("ill_imm_ext", 64'(imm_ext), 64'd0);
`ifdef IMM_GEN_ERR_EN
    chk("ill_out_err", {63'd0, out_err}, 64'd1);
`else
    chk("ill_out_err", {63'd0, out_err}, 64'd0);
`endif
    cycle(1'b0, '0, 3'd0, 1'b1);

    // Three back-to-back offers while stalled: two fit, the third sees in_ready low.
    cycle(1'b1, 25'h0123456, 3'd0, 1'b0);
    cycle(1'b1, 25'h1234567, 3'd1, 1'b0);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    cycle(1'b1, 25'h0ABCDEF, 3'd3, 1'b0);
    cycle(1'b0, '0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 3'd0, 1'b1);

    // Fill O and S, then reset: nothing stale may come out afterwards.
    cycle(1'b1, 25'h1555555, 3'd4, 1'b0);
    cycle(1'b1, 25'h0AAAAAA, 3'd2, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 3'd0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic iv;
      logic ordy;
      iv   = ($urandom % 4) != 0;
      ordy = (i < 300) ? (($urandom % 2) != 0) : (($urandom % 5) != 0);
      cycle(iv, 25'($urandom), 3'($urandom_range(0, 7)), ordy);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 3'd0, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
